// File: rtl/n4_c2_abs_arbiter_if.sv
// Req/ack handshake bundle between two signed 4-bit producers and the shared abs arbiter.
// Requesters hold req and operand until ack; the arbiter returns ack with a registered result.
interface n4_c2_abs_arbiter_if;
  logic       req0;
  logic [3:0] x0_3_x0_0;
  logic       req1;
  logic [3:0] x1_3_x1_0;
  logic       ack0;
  logic       ack1;
  logic [3:0] z3_z0;
  logic       ovf;
  logic       gnt;

  modport master (
    output req0, x0_3_x0_0, req1, x1_3_x1_0,
    input  ack0, ack1, z3_z0, ovf, gnt
  );

  modport slave (
    input  req0, x0_3_x0_0, req1, x1_3_x1_0,
    output ack0, ack1, z3_z0, ovf, gnt
  );
endinterface

// File: rtl/n4_c2_abs_arbiter.sv
// Round-robin sharing of one 4-bit two's-complement abs unit between two 4-phase requesters.
// Result and ack appear one edge after a sampled req; ack holds until req drops, and the other req waits.
module n4_c2_abs_x (
  input  logic [3:0] x,
  output logic [3:0] z,
  output logic       ovf
);
  // -8 negates to itself, so z is 1000 exactly when ovf is set
  assign z   = x[3] ? (~x + 4'd1) : x;
  assign ovf = (x == 4'b1000);
endmodule

module n4_c2_abs_arbiter (
  input  logic                      clock,
  input  logic                      reset,
  n4_c2_abs_arbiter_if.slave        bus
);
  typedef enum logic {IDLE, ACK} state_t;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic       ack0_q, ack0_nxt;
  logic       ack1_q, ack1_nxt;
  logic [3:0] z_q, z_nxt;
  logic       ovf_q, ovf_nxt;
  logic       gnt_q, gnt_nxt;

  logic       sel;
  logic [3:0] x_sel;
  logic [3:0] abs_z;
  logic       abs_ovf;
  logic       req_gnt;

  // On a tie the requester that was not served last wins
  assign sel     = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign x_sel   = sel ? bus.x1_3_x1_0 : bus.x0_3_x0_0;
  assign req_gnt = gnt_q ? bus.req1 : bus.req0;

  n4_c2_abs_x u_abs (
    .x   (x_sel),
    .z   (abs_z),
    .ovf (abs_ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      z_q    <= 4'b0000;
      ovf_q  <= 1'b0;
      gnt_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      ack0_q <= ack0_nxt;
      ack1_q <= ack1_nxt;
      z_q    <= z_nxt;
      ovf_q  <= ovf_nxt;
      gnt_q  <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    ack0_nxt  = ack0_q;
    ack1_nxt  = ack1_q;
    z_nxt     = z_q;
    ovf_nxt   = ovf_q;
    gnt_nxt   = gnt_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          z_nxt     = abs_z;
          ovf_nxt   = abs_ovf;
          gnt_nxt   = sel;
          last_nxt  = sel;
          ack0_nxt  = ~sel;
          ack1_nxt  = sel;
          state_nxt = ACK;
        end
      end
      ACK: begin
        // Releasing edge never grants, so a waiting requester gets the next edge
        if (!req_gnt) begin
          ack0_nxt  = 1'b0;
          ack1_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.z3_z0 = z_q;
  assign bus.ovf   = ovf_q;
  assign bus.gnt   = gnt_q;
endmodule

// File: tb/tb_n4_c2_abs_arbiter.sv
// Bench for n4_c2_abs_arbiter: directed vector table, handshake corner sequences, random agents vs model.
module tb_n4_c2_abs_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  n4_c2_abs_arbiter_if bus ();

  n4_c2_abs_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       r0;
    logic [3:0] x0;
    logic       r1;
    logic [3:0] x1;
    logic [7:0] exp;   // {ack0, ack1, z, ovf, gnt}
  } vec_t;

  vec_t vecs [13];

  function automatic logic [7:0] pk(logic a0, logic a1, logic [3:0] z, logic o, logic g);
    return {a0, a1, z, o, g};
  endfunction

  function automatic logic [7:0] outs();
    return {bus.ack0, bus.ack1, bus.z3_z0, bus.ovf, bus.gnt};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(logic r0, logic [3:0] x0, logic r1, logic [3:0] x1);
    bus.req0 = r0; bus.x0_3_x0_0 = x0;
    bus.req1 = r1; bus.x1_3_x1_0 = x1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // Reference: signed value of the operand, magnitude by plain integer arithmetic
  function automatic logic [4:0] ref_abs(logic [3:0] x);
    int v, m;
    logic [3:0] z;
    v = x[3] ? int'(x) - 16 : int'(x);
    m = (v < 0) ? -v : v;
    z = m[3:0];
    return {z, (v == -8)};
  endfunction

  int owner, m_last;
  logic [3:0] m_z;
  logic m_ovf, m_gnt;

  initial begin
    logic [7:0] e;
    logic [4:0] ra;
    int ngr, viol;
    logic prev_any, any;
    logic r0, r1;
    logic [3:0] x0, x1;

    drive(1'b0, 4'd0, 1'b0, 4'd0);

    // reset state, observed while reset is high
    @(negedge clock);
    reset = 1'b1;
    #1 check("reset_state", outs(), 8'b0);
    #1 reset = 1'b0;

    vecs[0]  = '{1'b1, 4'b1011, 1'b0, 4'b0000, pk(1, 0, 4'b0101, 0, 0)};
    vecs[1]  = '{1'b0, 4'b1011, 1'b0, 4'b0000, pk(0, 0, 4'b0101, 0, 0)};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, pk(0, 1, 4'b1000, 1, 1)};
    vecs[3]  = '{1'b1, 4'b0111, 1'b1, 4'b1000, pk(0, 1, 4'b1000, 1, 1)};
    vecs[4]  = '{1'b1, 4'b0111, 1'b0, 4'b1000, pk(0, 0, 4'b1000, 1, 1)};
    vecs[5]  = '{1'b1, 4'b0111, 1'b0, 4'b0000, pk(1, 0, 4'b0111, 0, 0)};
    vecs[6]  = '{1'b0, 4'b0111, 1'b0, 4'b0000, pk(0, 0, 4'b0111, 0, 0)};
    vecs[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, pk(1, 0, 4'b0000, 0, 0)};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, pk(0, 0, 4'b0000, 0, 0)};
    vecs[9]  = '{1'b1, 4'b0011, 1'b1, 4'b1111, pk(0, 1, 4'b0001, 0, 1)};
    vecs[10] = '{1'b1, 4'b0011, 1'b0, 4'b1111, pk(0, 0, 4'b0001, 0, 1)};
    vecs[11] = '{1'b1, 4'b0011, 1'b0, 4'b1111, pk(1, 0, 4'b0011, 0, 0)};
    vecs[12] = '{1'b0, 4'b0011, 1'b0, 4'b1111, pk(0, 0, 4'b0011, 0, 0)};

    @(negedge clock);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r0, vecs[i].x0, vecs[i].r1, vecs[i].x1);
      cyc();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // both requests from reset: 0 first, one idle edge on handover, then 1
    do_reset();
    drive(1'b1, 4'b0011, 1'b1, 4'b1111);
    cyc();
    check("tie_first", outs(), pk(1, 0, 4'b0011, 0, 0));
    bus.req0 = 1'b0;
    cyc();
    check("handover_idle", outs(), pk(0, 0, 4'b0011, 0, 0));
    cyc();
    check("handover_gnt1", outs(), pk(0, 1, 4'b0001, 0, 1));

    // fairness with continuously re-raised requests
    do_reset();
    drive(1'b1, 4'b0010, 1'b1, 4'b1110);
    ngr = 0; viol = 0; prev_any = 1'b0;
    for (int c = 0; c < 80 && ngr < 6; c++) begin
      cyc();
      if (bus.ack0 && bus.ack1) viol++;
      any = bus.ack0 | bus.ack1;
      if (any && !prev_any) begin
        check($sformatf("fair_gnt%0d", ngr), {7'b0, bus.gnt}, {7'b0, ngr[0]});
        ngr++;
      end
      prev_any = any;
      if (bus.req0 && bus.ack0) bus.req0 = 1'b0;
      else if (!bus.req0 && !bus.ack0) bus.req0 = 1'b1;
      if (bus.req1 && bus.ack1) bus.req1 = 1'b0;
      else if (!bus.req1 && !bus.ack1) bus.req1 = 1'b1;
    end
    check("fair_count", ngr[7:0], 8'd6);
    check("fair_no_dual_ack", viol[7:0], 8'd0);

    // asynchronous reset during an ack1 transaction
    do_reset();
    drive(1'b0, 4'b0000, 1'b1, 4'b1001);
    cyc();
    check("pre_reset_ack1", outs(), pk(0, 1, 4'b0111, 0, 1));
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), 8'b0);
    bus.req0 = 1'b1; bus.x0_3_x0_0 = 4'b0101;
    #1 reset = 1'b0;
    cyc();
    check("post_reset_req0_wins", outs(), pk(1, 0, 4'b0101, 0, 0));

    // unsampled pulse on req0 is ignored
    drive(1'b0, 4'b0101, 1'b0, 4'b1001);
    cyc();
    check("release_all", outs(), pk(0, 0, 4'b0101, 0, 0));
    #1 bus.req0 = 1'b1; bus.x0_3_x0_0 = 4'b1111;
    #2 bus.req0 = 1'b0;
    cyc();
    check("pulse_ignored", outs(), pk(0, 0, 4'b0101, 0, 0));

    // randomized requesters against the transaction-level model
    do_reset();
    owner = -1; m_last = 1; m_z = 4'b0; m_ovf = 1'b0; m_gnt = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 600; c++) begin
      r0 = bus.req0; r1 = bus.req1; x0 = bus.x0_3_x0_0; x1 = bus.x1_3_x1_0;
      if (!r0 && !bus.ack0 && $urandom_range(2, 0) == 0) begin r0 = 1'b1; x0 = 4'($urandom); end
      else if (r0 && bus.ack0 && $urandom_range(1, 0) == 0) r0 = 1'b0;
      if (!r1 && !bus.ack1 && $urandom_range(2, 0) == 0) begin r1 = 1'b1; x1 = 4'($urandom); end
      else if (r1 && bus.ack1 && $urandom_range(1, 0) == 0) r1 = 1'b0;
      drive(r0, x0, r1, x1);
      @(posedge clock);
      if (owner < 0) begin
        if (r0 || r1) begin
          owner = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
          m_last = owner;
          ra = ref_abs(owner == 1 ? x1 : x0);
          m_z = ra[4:1]; m_ovf = ra[0]; m_gnt = (owner == 1);
        end
      end else if ((owner == 0 && !r0) || (owner == 1 && !r1)) begin
        owner = -1;
      end
      @(negedge clock);
      e = pk(owner == 0, owner == 1, m_z, m_ovf, m_gnt);
      check($sformatf("rand%0d", c), outs(), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n4_c2_abs_arbiter.md
# n4_c2_abs_arbiter

Shares a single 4-bit two's-complement absolute-value unit (one `n4_c2_abs_x` instance) between two requesters over 4-phase req/ack handshakes. Grants are round-robin, and each result is registered together with the granted requester's id and an overflow flag. The block sits between two independent producers of signed 4-bit operands and the shared abs datapath. Only one abs instance exists; the block owns all sequencing of it.

## Interface
- No parameters (width fixed at 4 bits, requesters fixed at 2).
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  request from requester 0 (4-phase).
- `x0_3_x0_0`  in  4  operand of requester 0, two's complement; stable while `req0`=1 and `ack0`=0.
- `req1`  in  1  request from requester 1 (4-phase).
- `x1_3_x1_0`  in  4  operand of requester 1; same stability rule.
- `ack0`  out  1  acknowledge to requester 0; result valid while high.
- `ack1`  out  1  acknowledge to requester 1.
- `z3_z0`  out  4  registered |x| of the last granted operand.
- `ovf`  out  1  registered; 1 iff the granted operand was 1000 (|−8| not representable, `z3_z0`=1000).
- `gnt`  out  1  registered id of the requester owning `z3_z0`/`ovf`.

## Operation
- Reset (asynchronous, immediate): `ack0`=`ack1`=0, `z3_z0`=0000, `ovf`=0, `gnt`=0, state IDLE, internal `last`=1 (so requester 0 wins the first tie).
- FSM, two states:
  - IDLE: if neither req is high, stay.
    - If exactly one req is high, select it.
    - If both are high, select the one ≠ `last`.
    - On that edge: `z3_z0` ← abs(selected operand), `ovf` ← (operand==1000), `gnt` ← sel, `last` ← sel, `ack_sel` ← 1, go to ACK.
  - ACK: hold `ack_gnt`=1 and all result registers.
    - On the edge where `req_gnt` is sampled 0: `ack_gnt` ← 0, go to IDLE.
    - The other requester's req is ignored in this state.
- The abs datapath is combinational on a mux of the two operands, with the mux driven by the IDLE selection. Only the registered outputs are visible.
- Exactly one grant is in flight at a time. `ack0` and `ack1` are never both 1.
- `z3_z0`, `ovf` and `gnt` hold their last values indefinitely after the handshake completes; they change only on a grant edge.
- A req that drops in IDLE before being sampled is simply not served. No error is raised.

## Timing
- Grant latency: req sampled high at edge N (in IDLE) → `ack` and result visible after edge N.
- Release: `req_gnt` sampled low at edge M → `ack` low after edge M.
- Minimum transaction length is 2 cycles; back-to-back grants are separated by at least one IDLE edge.
- Handover case: `req_gnt` drops while the other req is already high.
  - The ACK→IDLE edge does not grant.
  - The other requester is granted on the following edge.
- Fairness: with both reqs held continuously and each requester dropping req one cycle after ack, grants alternate 0,1,0,1…
- Mid-operation reset:
  - Ack drops asynchronously and `last` returns to 1.
  - A req still high after reset deassertion is served afresh (`req0` wins if both are high).

## Test plan
- Reset, then `req0`=1, `x0`=1011 (−5) → after next edge `ack0`=1, `z3_z0`=0101, `ovf`=0, `gnt`=0. Drop `req0` → `ack0`=0 one edge later; `z3_z0` stays 0101.
- Both reqs high from reset, `x0`=0011, `x1`=1111 → first grant `gnt`=0, z=0011. After `req0` drops: one IDLE edge, then `gnt`=1, z=0001, `ack1`=1.
- `x1`=1000 alone → z=1000, `ovf`=1, `gnt`=1. Next `x0`=0111 → z=0111, `ovf`=0.
- Both reqs held continuously; each requester drops req one cycle after its ack and re-raises it one cycle later, over 6 transactions → gnt sequence 0,1,0,1,0,1. Check `ack0`&`ack1` never both 1.
- Assert `reset` while `ack1`=1 → `ack1` drops without waiting for a clock, outputs return to reset values. Keep both reqs high after release → first grant goes to 0.
- `req0` pulsed high between edges (never sampled) → no ack, outputs unchanged. Operand 0000 → z=0000, `ovf`=0.
